// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions used by the master bridge and the slave wrappers.
// Response codes and error classification live here so both ends agree on them.
package axi4_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] PROT_DEFAULT = 3'b000;

    // EXOKAY is a success; only SLVERR and DECERR are errors.
    function automatic logic resp_is_err(input logic [1:0] resp);
        logic err_s;
        case (resp)
            RESP_OKAY, RESP_EXOKAY:   err_s = 1'b0;
            RESP_SLVERR, RESP_DECERR: err_s = 1'b1;
            default:                  err_s = 1'b1;
        endcase
        return err_s;
    endfunction

endpackage

// File: rtl/axi4_lite_master_bridge.sv
// Single-outstanding AXI4-Lite master: turns a simple request/done handshake
// into one AXI4-Lite read or write, with all channel outputs registered.
module axi4_lite_master_bridge
    import axi4_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      iCLK,
    input  logic                      iRST,
    input  logic                      iREQ,
    input  logic                      iWE,
    input  logic [ADDR_WIDTH-1:0]     iADDR,
    input  logic [DATA_WIDTH-1:0]     iWDATA,
    input  logic [DATA_WIDTH/8-1:0]   iWSTRB,
    output logic                      oREADY,
    output logic                      oDONE,
    output logic                      oERR,
    output logic [DATA_WIDTH-1:0]     oRDATA,
    output logic                      m_AWVALID,
    input  logic                      m_AWREADY,
    output logic [ADDR_WIDTH-1:0]     m_AWADDR,
    output logic [2:0]                m_AWPROT,
    output logic                      m_WVALID,
    input  logic                      m_WREADY,
    output logic [DATA_WIDTH-1:0]     m_WDATA,
    output logic [DATA_WIDTH/8-1:0]   m_WSTRB,
    input  logic                      m_BVALID,
    output logic                      m_BREADY,
    input  logic [1:0]                m_BRESP,
    output logic                      m_ARVALID,
    input  logic                      m_ARREADY,
    output logic [ADDR_WIDTH-1:0]     m_ARADDR,
    output logic [2:0]                m_ARPROT,
    input  logic                      m_RVALID,
    output logic                      m_RREADY,
    input  logic [DATA_WIDTH-1:0]     m_RDATA,
    input  logic [1:0]                m_RRESP
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_WRESP = 3'd2,
        ST_RADDR = 3'd3,
        ST_RDATA = 3'd4
    } state_e;

    state_e                    state_q;
    logic                      ready_q;
    logic                      done_q;
    logic                      err_q;
    logic [DATA_WIDTH-1:0]     rdata_q;
    logic                      awvalid_q;
    logic                      wvalid_q;
    logic                      bready_q;
    logic                      arvalid_q;
    logic                      rready_q;
    logic                      we_q;
    logic [ADDR_WIDTH-1:0]     addr_q;
    logic [DATA_WIDTH-1:0]     wdata_q;
    logic [DATA_WIDTH/8-1:0]   wstrb_q;

    // Write-phase exit: each channel is finished once its VALID has dropped or handshakes now.
    logic aw_fin_s;
    logic w_fin_s;
    assign aw_fin_s = !awvalid_q || m_AWREADY;
    assign w_fin_s  = !wvalid_q  || m_WREADY;

    // Transaction FSM together with the request latch and every registered output.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q   <= ST_IDLE;
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= {DATA_WIDTH{1'b0}};
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= {ADDR_WIDTH{1'b0}};
            wdata_q   <= {DATA_WIDTH{1'b0}};
            wstrb_q   <= {(DATA_WIDTH/8){1'b0}};
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    ready_q <= 1'b1;
                    if (iREQ && ready_q) begin
                        ready_q <= 1'b0;
                        we_q    <= iWE;
                        addr_q  <= iADDR;
                        wdata_q <= iWDATA;
                        wstrb_q <= iWSTRB;
                        if (iWE) begin
                            state_q   <= ST_WRITE;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                        end else begin
                            state_q   <= ST_RADDR;
                            arvalid_q <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    if (m_AWREADY) begin
                        awvalid_q <= 1'b0;
                    end
                    if (m_WREADY) begin
                        wvalid_q <= 1'b0;
                    end
                    if (aw_fin_s && w_fin_s) begin
                        state_q  <= ST_WRESP;
                        bready_q <= 1'b1;
                    end
                end
                ST_WRESP: begin
                    if (m_BVALID) begin
                        state_q  <= ST_IDLE;
                        bready_q <= 1'b0;
                        done_q   <= 1'b1;
                        err_q    <= resp_is_err(m_BRESP);
                        ready_q  <= 1'b1;
                    end
                end
                ST_RADDR: begin
                    if (m_ARREADY) begin
                        state_q   <= ST_RDATA;
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                    end
                end
                ST_RDATA: begin
                    if (m_RVALID) begin
                        state_q  <= ST_IDLE;
                        rready_q <= 1'b0;
                        rdata_q  <= m_RDATA;
                        done_q   <= 1'b1;
                        err_q    <= resp_is_err(m_RRESP);
                        ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    ready_q   <= 1'b0;
                    awvalid_q <= 1'b0;
                    wvalid_q  <= 1'b0;
                    bready_q  <= 1'b0;
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b0;
                end
            endcase
        end
    end

    assign oREADY = ready_q;
    assign oDONE  = done_q;
    assign oERR   = err_q;
    assign oRDATA = rdata_q;

    // The shared address register feeds only the channel matching the latched request type.
    assign m_AWVALID = awvalid_q;
    assign m_AWADDR  = we_q ? addr_q : {ADDR_WIDTH{1'b0}};
    assign m_AWPROT  = PROT_DEFAULT;
    assign m_WVALID  = wvalid_q;
    assign m_WDATA   = wdata_q;
    assign m_WSTRB   = wstrb_q;
    assign m_BREADY  = bready_q;
    assign m_ARVALID = arvalid_q;
    assign m_ARADDR  = we_q ? {ADDR_WIDTH{1'b0}} : addr_q;
    assign m_ARPROT  = PROT_DEFAULT;
    assign m_RREADY  = rready_q;

endmodule

// File: tb/tb_axi4_lite_master_bridge.sv
// Self-checking bench for axi4_lite_master_bridge: a delay-programmable slave
// model plus a latency/response reference computed from the transfer rules.
module tb_axi4_lite_master_bridge;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic        iREQ;
    logic        iWE;
    logic [31:0] iADDR;
    logic [31:0] iWDATA;
    logic [3:0]  iWSTRB;
    logic        oREADY, oDONE, oERR;
    logic [31:0] oRDATA;
    logic        m_AWVALID, m_AWREADY, m_WVALID, m_WREADY, m_BVALID, m_BREADY;
    logic        m_ARVALID, m_ARREADY, m_RVALID, m_RREADY;
    logic [31:0] m_AWADDR, m_WDATA, m_ARADDR, m_RDATA;
    logic [3:0]  m_WSTRB;
    logic [2:0]  m_AWPROT, m_ARPROT;
    logic [1:0]  m_BRESP, m_RRESP;

    int tests_run = 0;
    int tests_failed = 0;

    // Slave configuration, set by the test tasks.
    int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    logic [31:0] rdata_cfg = 32'h0;

    // Slave state and cumulative monitors.
    int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    logic        aw_got, w_got, ar_got;
    logic        aw_hold, w_hold, ar_hold;
    logic [31:0] awaddr_last, wdata_last, araddr_last;
    logic [3:0]  wstrb_last;
    int          aw_hs_tot = 0, w_hs_tot = 0, ar_hs_tot = 0, viol_tot = 0;
    int          viol_now;
    logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
    logic [3:0]  cap_wstrb;

    always #5 iCLK = ~iCLK;

    axi4_lite_master_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .iCLK(iCLK), .iRST(iRST), .iREQ(iREQ), .iWE(iWE), .iADDR(iADDR),
        .iWDATA(iWDATA), .iWSTRB(iWSTRB), .oREADY(oREADY), .oDONE(oDONE),
        .oERR(oERR), .oRDATA(oRDATA),
        .m_AWVALID(m_AWVALID), .m_AWREADY(m_AWREADY), .m_AWADDR(m_AWADDR), .m_AWPROT(m_AWPROT),
        .m_WVALID(m_WVALID), .m_WREADY(m_WREADY), .m_WDATA(m_WDATA), .m_WSTRB(m_WSTRB),
        .m_BVALID(m_BVALID), .m_BREADY(m_BREADY), .m_BRESP(m_BRESP),
        .m_ARVALID(m_ARVALID), .m_ARREADY(m_ARREADY), .m_ARADDR(m_ARADDR), .m_ARPROT(m_ARPROT),
        .m_RVALID(m_RVALID), .m_RREADY(m_RREADY), .m_RDATA(m_RDATA), .m_RRESP(m_RRESP)
    );

    assign m_AWREADY = m_AWVALID && (aw_cnt >= aw_dly);
    assign m_WREADY  = m_WVALID && (w_cnt >= w_dly);
    assign m_BVALID  = aw_got && w_got && (b_cnt >= b_dly);
    assign m_BRESP   = bresp_cfg;
    assign m_ARREADY = m_ARVALID && (ar_cnt >= ar_dly);
    assign m_RVALID  = ar_got && (r_cnt >= r_dly);
    assign m_RDATA   = rdata_cfg;
    assign m_RRESP   = rresp_cfg;

    // Protocol violations seen this cycle: unstable/withdrawn VALID, early READY, nonzero PROT.
    always_comb begin
        viol_now = 0;
        if (aw_hold && (!m_AWVALID || m_AWADDR !== awaddr_last)) viol_now = viol_now + 1;
        if (w_hold && (!m_WVALID || m_WDATA !== wdata_last || m_WSTRB !== wstrb_last)) viol_now = viol_now + 1;
        if (ar_hold && (!m_ARVALID || m_ARADDR !== araddr_last)) viol_now = viol_now + 1;
        if (m_BREADY && !(aw_got && w_got)) viol_now = viol_now + 1;
        if (m_RREADY && !ar_got) viol_now = viol_now + 1;
        if (m_AWVALID && m_AWPROT !== 3'b000) viol_now = viol_now + 1;
        if (m_ARVALID && m_ARPROT !== 3'b000) viol_now = viol_now + 1;
    end

    // Slave model: delayed READYs, response after both write handshakes / after AR.
    always @(posedge iCLK) begin
        if (iRST) begin
            aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
            aw_hold <= 1'b0; w_hold <= 1'b0; ar_hold <= 1'b0;
        end else begin
            viol_tot <= viol_tot + viol_now;
            aw_hold <= m_AWVALID && !m_AWREADY; awaddr_last <= m_AWADDR;
            w_hold  <= m_WVALID && !m_WREADY;   wdata_last <= m_WDATA; wstrb_last <= m_WSTRB;
            ar_hold <= m_ARVALID && !m_ARREADY; araddr_last <= m_ARADDR;
            if (m_AWVALID && m_AWREADY) begin
                aw_got <= 1'b1; aw_cnt <= 0; aw_hs_tot <= aw_hs_tot + 1; cap_awaddr <= m_AWADDR;
            end else if (m_AWVALID) aw_cnt <= aw_cnt + 1;
            if (m_WVALID && m_WREADY) begin
                w_got <= 1'b1; w_cnt <= 0; w_hs_tot <= w_hs_tot + 1;
                cap_wdata <= m_WDATA; cap_wstrb <= m_WSTRB;
            end else if (m_WVALID) w_cnt <= w_cnt + 1;
            if (m_BVALID && m_BREADY) begin
                aw_got <= 1'b0; w_got <= 1'b0; b_cnt <= 0;
            end else if (aw_got && w_got) b_cnt <= b_cnt + 1;
            if (m_ARVALID && m_ARREADY) begin
                ar_got <= 1'b1; ar_cnt <= 0; ar_hs_tot <= ar_hs_tot + 1; cap_araddr <= m_ARADDR;
            end else if (m_ARVALID) ar_cnt <= ar_cnt + 1;
            if (m_RVALID && m_RREADY) begin
                ar_got <= 1'b0; r_cnt <= 0;
            end else if (ar_got) r_cnt <= r_cnt + 1;
        end
    end

    // Issue one request (caller guarantees oREADY=1) and wait, bounded, for oDONE.
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, output int lat, output logic err,
                           output logic rdy, output logic done_after);
        int cyc;
        iREQ = 1'b1; iWE = we; iADDR = addr; iWDATA = wdata; iWSTRB = strb;
        @(posedge iCLK); #1;
        iREQ = 1'b0;
        cyc = 1;
        while (oDONE !== 1'b1 && cyc < 200) begin
            @(posedge iCLK); #1;
            cyc++;
        end
        lat = cyc; err = oERR; rdy = oREADY;
        @(posedge iCLK); #1;
        done_after = oDONE;
    endtask

    task automatic test_reset();
        iRST = 1'b1; iREQ = 1'b0; iWE = 1'b0; iADDR = 32'h0; iWDATA = 32'h0; iWSTRB = 4'h0;
        repeat (3) @(posedge iCLK);
        #1;
        tests_run++;
        if ({oREADY, oDONE, oERR, m_AWVALID, m_WVALID, m_ARVALID, m_BREADY, m_RREADY} !== 8'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b, want 00000000",
                     {oREADY, oDONE, oERR, m_AWVALID, m_WVALID, m_ARVALID, m_BREADY, m_RREADY});
        end
        tests_run++;
        if ({oRDATA, m_AWADDR, m_ARADDR, m_WDATA, m_WSTRB} !== 132'b0) begin
            tests_failed++;
            $display("FAIL reset_data: rdata=%h awaddr=%h araddr=%h wdata=%h wstrb=%h, want 0",
                     oRDATA, m_AWADDR, m_ARADDR, m_WDATA, m_WSTRB);
        end
        iRST = 1'b0;
        @(posedge iCLK); #1;
        tests_run++;
        if (oREADY !== 1'b1 || oDONE !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release: ready=%b done=%b, want 1/0", oREADY, oDONE);
        end
    endtask

    task automatic test_write_basic();
        int lat; logic err, rdy, da; int aw0, w0, v0;
        aw_dly = 0; w_dly = 0; b_dly = 0; bresp_cfg = 2'b00;
        aw0 = aw_hs_tot; w0 = w_hs_tot; v0 = viol_tot;
        run_txn(1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 4'hF, lat, err, rdy, da);
        tests_run++;
        if (lat !== 3 || err !== 1'b0 || rdy !== 1'b1 || da !== 1'b0) begin
            tests_failed++;
            $display("FAIL write_basic: lat=%0d err=%b ready=%b done_after=%b, want 3/0/1/0", lat, err, rdy, da);
        end
        tests_run++;
        if (cap_awaddr !== 32'h1000_0004 || cap_wdata !== 32'hDEAD_BEEF || cap_wstrb !== 4'hF) begin
            tests_failed++;
            $display("FAIL write_basic_data: addr=%h data=%h strb=%h, want 10000004/deadbeef/f",
                     cap_awaddr, cap_wdata, cap_wstrb);
        end
        tests_run++;
        if (aw_hs_tot - aw0 !== 1 || w_hs_tot - w0 !== 1 || viol_tot - v0 !== 0) begin
            tests_failed++;
            $display("FAIL write_basic_hs: aw=%0d w=%0d viol=%0d, want 1/1/0",
                     aw_hs_tot - aw0, w_hs_tot - w0, viol_tot - v0);
        end
    endtask

    task automatic test_read_delay();
        int lat; logic err, rdy, da; int ar0, v0;
        ar_dly = 4; r_dly = 0; rresp_cfg = 2'b00; rdata_cfg = 32'h0000_00A5;
        ar0 = ar_hs_tot; v0 = viol_tot;
        run_txn(1'b0, 32'h2000_0003, 32'h0, 4'h0, lat, err, rdy, da);
        tests_run++;
        if (lat !== 7 || err !== 1'b0 || da !== 1'b0 || oRDATA !== 32'h0000_00A5) begin
            tests_failed++;
            $display("FAIL read_delay: lat=%0d err=%b done_after=%b rdata=%h, want 7/0/0/000000a5",
                     lat, err, da, oRDATA);
        end
        tests_run++;
        if (ar_hs_tot - ar0 !== 1 || viol_tot - v0 !== 0 || cap_araddr !== 32'h2000_0003) begin
            tests_failed++;
            $display("FAIL read_delay_ar: hs=%0d viol=%0d addr=%h, want 1/0/20000003",
                     ar_hs_tot - ar0, viol_tot - v0, cap_araddr);
        end
        ar_dly = 0;
    endtask

    task automatic test_w_before_aw();
        int lat; logic err, rdy, da; int aw0, w0, v0;
        aw_dly = 3; w_dly = 0; b_dly = 0; bresp_cfg = 2'b00;
        aw0 = aw_hs_tot; w0 = w_hs_tot; v0 = viol_tot;
        run_txn(1'b1, 32'h0000_0101, 32'h1234_5678, 4'h5, lat, err, rdy, da);
        tests_run++;
        if (lat !== 6 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL w_before_aw: lat=%0d err=%b, want 6/0", lat, err);
        end
        tests_run++;
        if (aw_hs_tot - aw0 !== 1 || w_hs_tot - w0 !== 1 || viol_tot - v0 !== 0) begin
            tests_failed++;
            $display("FAIL w_before_aw_hs: aw=%0d w=%0d viol=%0d, want 1/1/0",
                     aw_hs_tot - aw0, w_hs_tot - w0, viol_tot - v0);
        end
        aw_dly = 0;
    endtask

    task automatic test_errors();
        int lat; logic err, rdy, da;
        bresp_cfg = 2'b10;
        run_txn(1'b1, 32'h0000_0040, 32'h1, 4'h1, lat, err, rdy, da);
        tests_run++;
        if (err !== 1'b1 || lat !== 3) begin
            tests_failed++;
            $display("FAIL err_slverr: err=%b lat=%0d, want 1/3", err, lat);
        end
        rresp_cfg = 2'b11; rdata_cfg = 32'hBAD0_0BAD;
        run_txn(1'b0, 32'h0000_0044, 32'h0, 4'h0, lat, err, rdy, da);
        tests_run++;
        if (err !== 1'b1 || oRDATA !== 32'hBAD0_0BAD) begin
            tests_failed++;
            $display("FAIL err_decerr: err=%b rdata=%h, want 1/bad00bad", err, oRDATA);
        end
        rresp_cfg = 2'b00; rdata_cfg = 32'h0000_1111;
        run_txn(1'b0, 32'h0000_0048, 32'h0, 4'h0, lat, err, rdy, da);
        tests_run++;
        if (err !== 1'b0 || oRDATA !== 32'h0000_1111) begin
            tests_failed++;
            $display("FAIL err_okay_after: err=%b rdata=%h, want 0/00001111", err, oRDATA);
        end
        bresp_cfg = 2'b01;
        run_txn(1'b1, 32'h0000_004C, 32'h2, 4'h0, lat, err, rdy, da);
        tests_run++;
        if (err !== 1'b0 || oRDATA !== 32'h0000_1111) begin
            tests_failed++;
            $display("FAIL err_exokay: err=%b rdata=%h, want 0/00001111", err, oRDATA);
        end
        bresp_cfg = 2'b00;
    endtask

    task automatic test_ignore_busy();
        int cyc; int ar0;
        r_dly = 4; rdata_cfg = 32'h0000_00C3; rresp_cfg = 2'b00;
        iREQ = 1'b1; iWE = 1'b0; iADDR = 32'h3000_0000;
        @(posedge iCLK); #1;
        iREQ = 1'b0;
        cyc = 0;
        while (m_RREADY !== 1'b1 && cyc < 50) begin @(posedge iCLK); #1; cyc++; end
        ar0 = ar_hs_tot;
        iREQ = 1'b1; iWE = 1'b0; iADDR = 32'h3000_0ABC;
        cyc = 0;
        while (oDONE !== 1'b1 && cyc < 50) begin @(posedge iCLK); #1; cyc++; end
        tests_run++;
        if (ar_hs_tot - ar0 !== 0 || oRDATA !== 32'h0000_00C3 || oDONE !== 1'b1) begin
            tests_failed++;
            $display("FAIL busy_ignore: ar_hs=%0d rdata=%h done=%b, want 0/000000c3/1",
                     ar_hs_tot - ar0, oRDATA, oDONE);
        end
        r_dly = 0; rdata_cfg = 32'h0000_005A;
        @(posedge iCLK); #1;
        iREQ = 1'b0;
        cyc = 1;
        while (oDONE !== 1'b1 && cyc < 50) begin @(posedge iCLK); #1; cyc++; end
        tests_run++;
        if (cyc !== 3 || cap_araddr !== 32'h3000_0ABC || ar_hs_tot - ar0 !== 1 || oRDATA !== 32'h0000_005A) begin
            tests_failed++;
            $display("FAIL busy_accept: lat=%0d addr=%h ar_hs=%0d rdata=%h, want 3/30000abc/1/0000005a",
                     cyc, cap_araddr, ar_hs_tot - ar0, oRDATA);
        end
        @(posedge iCLK); #1;
    endtask

    task automatic test_reset_mid();
        int cyc; int dones; int lat; logic err, rdy, da;
        b_dly = 6; bresp_cfg = 2'b00;
        iREQ = 1'b1; iWE = 1'b1; iADDR = 32'h4000_0000; iWDATA = 32'h0F0F_0F0F; iWSTRB = 4'hF;
        @(posedge iCLK); #1;
        iREQ = 1'b0;
        cyc = 0;
        while (m_BREADY !== 1'b1 && cyc < 50) begin @(posedge iCLK); #1; cyc++; end
        iRST = 1'b1;
        @(posedge iCLK); #1;
        tests_run++;
        if ({m_AWVALID, m_WVALID, m_ARVALID, m_BREADY, m_RREADY, oDONE, oREADY} !== 7'b0) begin
            tests_failed++;
            $display("FAIL reset_mid: got %b, want 0000000",
                     {m_AWVALID, m_WVALID, m_ARVALID, m_BREADY, m_RREADY, oDONE, oREADY});
        end
        iRST = 1'b0; b_dly = 0;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge iCLK); #1;
            if (oDONE === 1'b1) dones++;
        end
        tests_run++;
        if (dones !== 0 || oREADY !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid_quiet: dones=%0d ready=%b, want 0/1", dones, oREADY);
        end
        run_txn(1'b1, 32'h4000_0010, 32'hCAFE_F00D, 4'h3, lat, err, rdy, da);
        tests_run++;
        if (lat !== 3 || err !== 1'b0 || cap_awaddr !== 32'h4000_0010 || cap_wdata !== 32'hCAFE_F00D) begin
            tests_failed++;
            $display("FAIL reset_mid_fresh: lat=%0d err=%b addr=%h data=%h, want 3/0/40000010/cafef00d",
                     lat, err, cap_awaddr, cap_wdata);
        end
    endtask

    // Random transfers against the reference: latency from channel delays, error from resp class.
    task automatic test_random();
        int lat, exp_lat; logic err, rdy, da, exp_err, we;
        logic [31:0] addr, wdata, rnd; logic [3:0] strb; logic [31:0] exp_rdata;
        int aw0, w0, ar0, v0;
        exp_rdata = oRDATA;
        for (int n = 0; n < 40; n++) begin
            we = $urandom_range(0, 1) == 1;
            addr = $urandom; wdata = $urandom; rnd = $urandom;
            strb = ($urandom_range(0, 3) == 0) ? 4'h0 : rnd[3:0];
            aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
            ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
            rnd = $urandom; bresp_cfg = rnd[1:0]; rresp_cfg = rnd[3:2];
            rdata_cfg = $urandom;
            aw0 = aw_hs_tot; w0 = w_hs_tot; ar0 = ar_hs_tot; v0 = viol_tot;
            if (we) begin
                exp_lat = ((aw_dly > w_dly) ? aw_dly : w_dly) + 3 + b_dly;
                exp_err = (bresp_cfg == 2'b10) || (bresp_cfg == 2'b11);
            end else begin
                exp_lat = 3 + ar_dly + r_dly;
                exp_err = (rresp_cfg == 2'b10) || (rresp_cfg == 2'b11);
                exp_rdata = rdata_cfg;
            end
            run_txn(we, addr, wdata, strb, lat, err, rdy, da);
            tests_run++;
            if (lat !== exp_lat || err !== exp_err || rdy !== 1'b1 || da !== 1'b0 || oRDATA !== exp_rdata) begin
                tests_failed++;
                $display("FAIL rand_%0d: we=%b lat=%0d/%0d err=%b/%b ready=%b done_after=%b rdata=%h/%h",
                         n, we, lat, exp_lat, err, exp_err, rdy, da, oRDATA, exp_rdata);
            end
            tests_run++;
            if (we && (cap_awaddr !== addr || cap_wdata !== wdata || cap_wstrb !== strb ||
                       aw_hs_tot - aw0 !== 1 || w_hs_tot - w0 !== 1 || ar_hs_tot - ar0 !== 0)) begin
                tests_failed++;
                $display("FAIL rand_wr_chan_%0d: addr=%h/%h data=%h/%h strb=%h/%h hs aw=%0d w=%0d ar=%0d",
                         n, cap_awaddr, addr, cap_wdata, wdata, cap_wstrb, strb,
                         aw_hs_tot - aw0, w_hs_tot - w0, ar_hs_tot - ar0);
            end else if (!we && (cap_araddr !== addr || ar_hs_tot - ar0 !== 1 ||
                                 aw_hs_tot - aw0 !== 0 || w_hs_tot - w0 !== 0)) begin
                tests_failed++;
                $display("FAIL rand_rd_chan_%0d: addr=%h/%h hs ar=%0d aw=%0d w=%0d",
                         n, cap_araddr, addr, ar_hs_tot - ar0, aw_hs_tot - aw0, w_hs_tot - w0);
            end
            tests_run++;
            if (viol_tot - v0 !== 0) begin
                tests_failed++;
                $display("FAIL rand_proto_%0d: violations=%0d, want 0", n, viol_tot - v0);
            end
        end
        aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
        bresp_cfg = 2'b00; rresp_cfg = 2'b00;
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_read_delay();
        test_w_before_aw();
        test_errors();
        test_ignore_busy();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
